// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift sequencer: shift opcodes, FSM states
// and the default number of bit positions shifted per clock.
package shift_pkg;

  localparam int SHIFT_PER_CYCLE_DEF = 4;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational short shifter: moves the operand by 0..SHIFT_PER_CYCLE positions
// in the direction selected by op, filling with zeros or the supplied sign bit.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = SHIFT_PER_CYCLE_DEF,
  parameter int DATA_WIDTH      = 32,
  parameter int STEP_W          = $clog2(SHIFT_PER_CYCLE + 1)
) (
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [STEP_W-1:0]     step,
  input  logic [1:0]            op,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [DATA_WIDTH-1:0] fill_mask;

  // Ones in the MSB positions vacated by a right shift of this step.
  assign fill_mask = ~({DATA_WIDTH{1'b1}} >> step);

  always_comb begin
    shifted = operand;
    case (op)
      SHIFT_SLL: shifted = operand << step;
      SHIFT_SRL: shifted = operand >> step;
      SHIFT_SRA: shifted = (operand >> step) | (fill_mask & {DATA_WIDTH{sign}});
      default:   shifted = operand;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: shifts at most SHIFT_PER_CYCLE bits per clock and
// stalls the pipeline until a one-cycle Done pulse presents the registered result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int SHIFT_PER_CYCLE = SHIFT_PER_CYCLE_DEF,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [1:0]            ShiftOp,
  input  logic [4:0]            Shamt,
  input  logic [DATA_WIDTH-1:0] DataInput,
  output logic [DATA_WIDTH-1:0] ShiftResult,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Stall,
  output logic                  IllegalOp
);

  localparam int STEP_W = $clog2(SHIFT_PER_CYCLE + 1);

  state_e                state, state_next;
  logic [DATA_WIDTH-1:0] work;
  logic [DATA_WIDTH-1:0] shifted;
  logic [1:0]            op;
  logic [5:0]            remaining;
  logic [5:0]            rem_after;
  logic [STEP_W-1:0]     step;
  logic                  accept;
  logic                  bypass;

  assign accept = (state == IDLE) && Start;
  assign bypass = (Shamt == 5'd0) || (ShiftOp == SHIFT_ILL);

  // step = min(remaining, SHIFT_PER_CYCLE); remaining never underflows.
  assign step      = (remaining < 6'(SHIFT_PER_CYCLE)) ? STEP_W'(remaining)
                                                       : STEP_W'(SHIFT_PER_CYCLE);
  assign rem_after = remaining - 6'(step);

  shift_step_unit #(
    .SHIFT_PER_CYCLE(SHIFT_PER_CYCLE),
    .DATA_WIDTH     (DATA_WIDTH),
    .STEP_W         (STEP_W)
  ) u_step (
    .operand(work),
    .step   (step),
    .op     (op),
    .sign   (work[DATA_WIDTH-1]),
    .shifted(shifted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = bypass ? DONE : SHIFT;
      SHIFT:   if (rem_after == 6'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work        <= '0;
      op          <= '0;
      remaining   <= '0;
      ShiftResult <= '0;
    end else if (accept) begin
      work      <= DataInput;
      op        <= ShiftOp;
      remaining <= {1'b0, Shamt};
      if (bypass) ShiftResult <= DataInput;
    end else if (state == SHIFT) begin
      work      <= shifted;
      remaining <= rem_after;
      if (rem_after == 6'd0) ShiftResult <= shifted;
    end
  end

  assign Done      = (state == DONE);
  assign IllegalOp = (state == DONE) && (op == SHIFT_ILL);
  assign Busy      = (state != IDLE);
  assign Stall     = accept || (state == SHIFT);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: requests push expected result/latency to a
// scoreboard queue, which is popped and compared when Done is observed.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  ShiftOp;
  logic [4:0]  Shamt;
  logic [31:0] DataInput;
  logic [31:0] ShiftResult;
  logic        Done, Busy, Stall, IllegalOp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] result;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  shift_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .ShiftOp    (ShiftOp),
    .Shamt      (Shamt),
    .DataInput  (DataInput),
    .ShiftResult(ShiftResult),
    .Done       (Done),
    .Busy       (Busy),
    .Stall      (Stall),
    .IllegalOp  (IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [4:0] sh,
                                 input logic [31:0] d);
    exp_t e;
    e.ill = (op == 2'b11);
    if (sh == 5'd0 || op == 2'b11) begin
      e.result = d;
      e.lat    = 1;
    end else begin
      case (op)
        2'b00:   e.result = d << sh;
        2'b01:   e.result = d >> sh;
        default: e.result = 32'($signed(d) >>> sh);
      endcase
      e.lat = (int'(sh) + 3) / 4 + 1;
    end
    return e;
  endfunction

  // hold=1 keeps Start high with different data through SHIFT and DONE.
  task automatic req(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                     input logic hold);
    exp_t e;
    int   n;
    bit   got;
    sb.push_back(model(op, sh, d));
    @(negedge clk);
    ShiftOp = op; Shamt = sh; DataInput = d; Start = 1'b1;
    #1 chk("stall_on_request", 32'(Stall), 32'd1);
    @(posedge clk);
    #1;
    Start     = hold;
    DataInput = $urandom;
    Shamt     = 5'($urandom_range(1, 31));
    ShiftOp   = 2'($urandom_range(0, 1));
    n   = 1;
    got = 0;
    while (n <= 40) begin
      @(negedge clk);
      if (Done) begin
        got = 1;
        break;
      end
      chk("busy_in_shift", 32'(Busy), 32'd1);
      chk("stall_in_shift", 32'(Stall), 32'd1);
      @(posedge clk);
      n++;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      e = sb.pop_front();
      chk("result", ShiftResult, e.result);
      chk("illegal", 32'(IllegalOp), 32'(e.ill));
      chk("latency", 32'(n), 32'(e.lat));
      chk("stall_in_done", 32'(Stall), 32'd0);
      chk("busy_in_done", 32'(Busy), 32'd1);
      Start = 1'b0;
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(Done), 32'd0);
      chk("idle_not_busy", 32'(Busy), 32'd0);
      chk("result_held", ShiftResult, e.result);
    end
  endtask

  initial begin
    reset = 1'b0; Start = 1'b0; ShiftOp = 2'b00; Shamt = 5'd0; DataInput = '0;
    #1;
    chk("rst_result", ShiftResult, 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_illegal", 32'(IllegalOp), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    req(2'b10, 5'd4,  32'h800000F0, 1'b0);
    req(2'b00, 5'd31, 32'h00000001, 1'b0);
    req(2'b01, 5'd5,  32'hFFFFFFFF, 1'b0);
    req(2'b00, 5'd0,  32'h12345678, 1'b0);
    req(2'b11, 5'd7,  32'hDEADBEEF, 1'b0);
    req(2'b10, 5'd13, 32'h7F00A5A5, 1'b0);
    req(2'b10, 5'd9,  32'hA5A5A5A5, 1'b0);

    // Start held high with other data during SHIFT and DONE: no second Done.
    req(2'b01, 5'd5, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_second_done", 32'(Done), 32'd0);
      chk("result_unchanged", ShiftResult, 32'h07FFFFFF);
    end

    // Reset during a long shift discards it.
    @(negedge clk);
    ShiftOp = 2'b00; Shamt = 5'd20; DataInput = 32'h0000_00FF; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", 32'(Busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_result", ShiftResult, 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_stall", 32'(Stall), 32'd0);
    chk("midrst_illegal", 32'(IllegalOp), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(Done), 32'd0);
    end
    req(2'b00, 5'd20, 32'h000000FF, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
